pcss_link_arb: RTL and testbench

Arbiter and serialiser that shares the single 16-bit east chip link of `pcss_top` between two 64-bit word sources: the configuration stream and the spike-injection stream. It sits between the host-side stream logic and the chip pins. It grants one source per packet, splits each 64-bit word into four 16-bit flits, drives the valid/parity link handshake, and retransmits a flit when the chip flags a parity error.

---
 rtl/pcss_pkg.sv | 26 ++
 rtl/pcss_link_ser.sv | 82 ++++++++
 rtl/pcss_link_arb.sv | 137 +++++++++++++
 tb/tb_pcss_link_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcss_pkg.sv
// Shared definitions for the pcss link path: default widths, flit count,
// link arbiter state encoding and a constant-safe ceil-log2 helper.
package pcss_pkg;

  localparam int unsigned DATA_WIDTH_DEF     = 64;
  localparam int unsigned CHIPDATA_WIDTH_DEF = 16;
  localparam int unsigned FLITS_DEF          = DATA_WIDTH_DEF / CHIPDATA_WIDTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_CHK   = 2'd3
  } link_arb_state_t;

  // Ceil-log2, never below 1 so index vectors keep a legal width.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pcss_link_ser.sv
// Word-to-flit serialiser for the chip link: holds the granted word, walks the
// flit index MSB first and rolls back on chip parity errors.
// Parity generation is enabled by PCSS_LINK_PARITY_EN.
module pcss_link_ser
  import pcss_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned CHIPDATA_WIDTH = CHIPDATA_WIDTH_DEF,
  parameter int unsigned NUM_FLITS      = FLITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [DATA_WIDTH-1:0]     load_data,
  input  logic                      load_last,
  input  logic                      xfer,
  input  logic                      rollback,
  input  logic                      resend_last,
  input  logic                      show,
  output logic                      last_flit_c,
  output logic                      word_last,
  output logic [CHIPDATA_WIDTH-1:0] send_data_out,
  output logic                      send_data_valid,
  output logic                      send_data_par
);

  localparam int unsigned IDX_W = log2(NUM_FLITS);

  logic [DATA_WIDTH-1:0]     word_q;
  logic [DATA_WIDTH-1:0]     word_d;
  logic [IDX_W-1:0]          idx_q;
  logic [IDX_W-1:0]          idx_d;
  logic                      last_d;
  logic [CHIPDATA_WIDTH-1:0] flit_d;
  int unsigned               shift_amt;

  assign last_flit_c = (idx_q == IDX_W'(NUM_FLITS - 1));

  // Next word/index; the output flit is taken from the next values so it is
  // valid the cycle after the word is captured.
  always_comb begin
    word_d    = word_q;
    idx_d     = idx_q;
    last_d    = word_last;
    if (load) begin
      word_d = load_data;
      idx_d  = '0;
      last_d = load_last;
    end else if (resend_last) begin
      idx_d = IDX_W'(NUM_FLITS - 1);
    end else if (rollback) begin
      if (idx_q != '0) idx_d = idx_q - 1'b1;
    end else if (xfer && !last_flit_c) begin
      idx_d = idx_q + 1'b1;
    end
    shift_amt = (NUM_FLITS - 1 - 32'(idx_d)) * CHIPDATA_WIDTH;
    flit_d    = CHIPDATA_WIDTH'(word_d >> shift_amt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q          <= '0;
      idx_q           <= '0;
      word_last       <= 1'b0;
      send_data_out   <= '0;
      send_data_valid <= 1'b0;
      send_data_par   <= 1'b0;
    end else begin
      word_q          <= word_d;
      idx_q           <= idx_d;
      word_last       <= last_d;
      send_data_out   <= show ? flit_d : '0;
      send_data_valid <= show;
`ifdef PCSS_LINK_PARITY_EN
      send_data_par   <= show & (^flit_d);
`else
      send_data_par   <= 1'b0;
`endif
    end
  end

endmodule

// File: rtl/pcss_link_arb.sv
// Arbitrates the cfg and spike word streams onto the 16-bit east chip link,
// one packet at a time. PCSS_LINK_PARITY_EN enables parity and retransmission.
module pcss_link_arb
  import pcss_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned CHIPDATA_WIDTH = CHIPDATA_WIDTH_DEF,
  parameter int unsigned CFG_PRIO       = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     cfg_tdata,
  input  logic                      cfg_tvalid,
  input  logic                      cfg_tlast,
  output logic                      cfg_tready,
  input  logic [DATA_WIDTH-1:0]     spk_tdata,
  input  logic                      spk_tvalid,
  input  logic                      spk_tlast,
  output logic                      spk_tready,
  output logic [CHIPDATA_WIDTH-1:0] send_data_out,
  output logic                      send_data_valid,
  output logic                      send_data_par,
  input  logic                      send_data_ready,
  input  logic                      send_data_err,
  output logic                      busy,
  output logic                      grant_spk
);

  localparam int unsigned FLITS = DATA_WIDTH / CHIPDATA_WIDTH;
`ifdef PCSS_LINK_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  link_arb_state_t state;
  link_arb_state_t state_d;

  logic last_spk;
  logic pick_spk;
  logic load;
  logic xfer;
  logic rollback;
  logic resend_last;
  logic show;
  logic last_flit_c;
  logic word_last;

  // Next state, grant choice and serialiser controls.
  always_comb begin
    state_d     = state;
    pick_spk    = grant_spk;
    load        = 1'b0;
    xfer        = 1'b0;
    rollback    = 1'b0;
    resend_last = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_tvalid || spk_tvalid) begin
          if (CFG_PRIO != 0) pick_spk = !cfg_tvalid;
          else               pick_spk = spk_tvalid && (!cfg_tvalid || !last_spk);
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_WAIT: begin
        if (grant_spk ? spk_tvalid : cfg_tvalid) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // An error voids any transfer this cycle: the chip drops trailing flits.
        if (PAR_EN && send_data_err) begin
          rollback = 1'b1;
        end else if (send_data_ready) begin
          xfer = 1'b1;
          if (last_flit_c) begin
            if (PAR_EN)         state_d = ST_CHK;
            else if (word_last) state_d = ST_IDLE;
            else                state_d = ST_WAIT;
          end
        end
      end
      ST_CHK: begin
        if (send_data_err) begin
          resend_last = 1'b1;
          state_d     = ST_SHIFT;
        end else begin
          state_d = word_last ? ST_IDLE : ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cfg_tready = load && !pick_spk && !rst;
    spk_tready = load &&  pick_spk && !rst;
    show       = (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      grant_spk <= 1'b0;
      last_spk  <= 1'b1;
    end else begin
      state <= state_d;
      busy  <= (state_d != ST_IDLE);
      if (load) begin
        grant_spk <= pick_spk;
        last_spk  <= pick_spk;
      end
    end
  end

  pcss_link_ser #(
    .DATA_WIDTH     (DATA_WIDTH),
    .CHIPDATA_WIDTH (CHIPDATA_WIDTH),
    .NUM_FLITS      (FLITS)
  ) u_ser (
    .clk             (clk),
    .rst             (rst),
    .load            (load),
    .load_data       (pick_spk ? spk_tdata : cfg_tdata),
    .load_last       (pick_spk ? spk_tlast : cfg_tlast),
    .xfer            (xfer),
    .rollback        (rollback),
    .resend_last     (resend_last),
    .show            (show),
    .last_flit_c     (last_flit_c),
    .word_last       (word_last),
    .send_data_out   (send_data_out),
    .send_data_valid (send_data_valid),
    .send_data_par   (send_data_par)
  );

endmodule

// File: tb/tb_pcss_link_arb.sv
// Directed self-checking bench for pcss_link_arb (priority and round-robin
// instances); expectations follow PCSS_LINK_PARITY_EN when it is defined.
module tb_pcss_link_arb;

`ifdef PCSS_LINK_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] cfg_tdata, spk_tdata;
  logic        cfg_tvalid, cfg_tlast, cfg_tready;
  logic        spk_tvalid, spk_tlast, spk_tready;
  logic [15:0] send_data_out;
  logic        send_data_valid, send_data_par, send_data_ready, send_data_err;
  logic        busy, grant_spk;

  logic        rr_cfg_tvalid, rr_cfg_tready, rr_spk_tvalid, rr_spk_tready;
  logic [15:0] rr_out;
  logic        rr_valid, rr_par, rr_busy, rr_grant;

  int checks = 0;
  int errors = 0;

  pcss_link_arb #(.DATA_WIDTH(64), .CHIPDATA_WIDTH(16), .CFG_PRIO(1)) dut (
    .clk(clk), .rst(rst),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tlast(cfg_tlast), .cfg_tready(cfg_tready),
    .spk_tdata(spk_tdata), .spk_tvalid(spk_tvalid), .spk_tlast(spk_tlast), .spk_tready(spk_tready),
    .send_data_out(send_data_out), .send_data_valid(send_data_valid), .send_data_par(send_data_par),
    .send_data_ready(send_data_ready), .send_data_err(send_data_err),
    .busy(busy), .grant_spk(grant_spk)
  );

  pcss_link_arb #(.DATA_WIDTH(64), .CHIPDATA_WIDTH(16), .CFG_PRIO(0)) dut_rr (
    .clk(clk), .rst(rst),
    .cfg_tdata(64'h1111_1111_1111_1111), .cfg_tvalid(rr_cfg_tvalid), .cfg_tlast(1'b1), .cfg_tready(rr_cfg_tready),
    .spk_tdata(64'h2222_2222_2222_2222), .spk_tvalid(rr_spk_tvalid), .spk_tlast(1'b1), .spk_tready(rr_spk_tready),
    .send_data_out(rr_out), .send_data_valid(rr_valid), .send_data_par(rr_par),
    .send_data_ready(1'b1), .send_data_err(1'b0),
    .busy(rr_busy), .grant_spk(rr_grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_par(input logic [15:0] f);
    return PAR_EN ? (^f) : 1'b0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_flit(input string tag, input logic [15:0] f);
    chk({tag, "_valid"}, 64'(send_data_valid), 64'd1);
    chk({tag, "_data"}, 64'(send_data_out), 64'(f));
    chk({tag, "_par"}, 64'(send_data_par), 64'(exp_par(f)));
  endtask

  task automatic offer_cfg_once(input logic [63:0] w);
    cfg_tdata  = w;
    cfg_tlast  = 1'b1;
    cfg_tvalid = 1'b1;
    tick;
    cfg_tvalid = 1'b0;
  endtask

  localparam logic [63:0] W0 = 64'h0123_4567_89AB_CDEF;

  logic [63:0] cw [3];
  logic [63:0] sw;
  logic [63:0] tmp;
  logic [15:0] got_f [$];
  logic        got_g [$];
  logic        got_p [$];
  logic        rr_g [$];
  logic        acc_c, acc_s;
  int          ci, si, cyc, spk_early;

  initial begin
    rst = 1'b1;
    cfg_tdata = '0; cfg_tvalid = 1'b1; cfg_tlast = 1'b0;
    spk_tdata = '0; spk_tvalid = 1'b0; spk_tlast = 1'b0;
    send_data_ready = 1'b0; send_data_err = 1'b0;
    rr_cfg_tvalid = 1'b0; rr_spk_tvalid = 1'b0;
    repeat (3) tick;

    // Reset state, with cfg offering a word that must not be accepted.
    chk("rst_out", 64'(send_data_out), 64'd0);
    chk("rst_valid", 64'(send_data_valid), 64'd0);
    chk("rst_par", 64'(send_data_par), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_spk), 64'd0);
    chk("rst_cfg_tready", 64'(cfg_tready), 64'd0);
    cfg_tvalid = 1'b0;
    rst = 1'b0;
    tick;

    // Single cfg word, ready held high.
    send_data_ready = 1'b1;
    cfg_tdata = W0; cfg_tlast = 1'b1; cfg_tvalid = 1'b1;
    #1;
    chk("t1_cfg_tready", 64'(cfg_tready), 64'd1);
    chk("t1_spk_tready", 64'(spk_tready), 64'd0);
    tick;
    cfg_tvalid = 1'b0;
    chk_flit("t1_f0", 16'h0123);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_grant", 64'(grant_spk), 64'd0);
    chk("t1_tready_shift", 64'(cfg_tready), 64'd0);
    tick; chk_flit("t1_f1", 16'h4567);
    tick; chk_flit("t1_f2", 16'h89AB);
    tick; chk_flit("t1_f3", 16'hCDEF);
    tick;
    chk("t1_n5_valid", 64'(send_data_valid), 64'd0);
    chk("t1_n5_busy", 64'(busy), 64'(PAR_EN));
    tick;
    chk("t1_n6_busy", 64'(busy), 64'd0);

    // Strict cfg priority: 3-word cfg packet then 1-word spk packet.
    cw[0] = 64'h0001_0003_0007_000F;
    cw[1] = 64'h1111_2222_4444_8888;
    cw[2] = 64'hFFFE_8001_00FF_0100;
    sw    = 64'hA5A5_5A5A_DEAD_BEEF;
    ci = 0; si = 0; cyc = 0; spk_early = 0;
    while (!(ci == 3 && si == 1 && busy == 1'b0) && cyc < 200) begin
      cfg_tvalid = (ci < 3);
      cfg_tdata  = cw[(ci < 3) ? ci : 0];
      cfg_tlast  = (ci == 2);
      spk_tvalid = (si < 1);
      spk_tdata  = sw;
      spk_tlast  = 1'b1;
      #1;
      if (spk_tready && ci < 3) spk_early++;
      acc_c = cfg_tready;
      acc_s = spk_tready;
      if (send_data_valid && send_data_ready) begin
        got_f.push_back(send_data_out);
        got_g.push_back(grant_spk);
        got_p.push_back(send_data_par);
      end
      tick;
      if (acc_c) ci++;
      if (acc_s) si++;
      cyc++;
    end
    cfg_tvalid = 1'b0; spk_tvalid = 1'b0;
    chk("t2_timeout", 64'(cyc < 200), 64'd1);
    chk("t2_cfg_words", 64'(ci), 64'd3);
    chk("t2_spk_words", 64'(si), 64'd1);
    chk("t2_spk_early", 64'(spk_early), 64'd0);
    chk("t2_nflits", 64'(got_f.size()), 64'd16);
    for (int i = 0; i < 16 && i < got_f.size(); i++) begin
      tmp = (i < 12) ? cw[i / 4] : sw;
      chk($sformatf("t2_flit%0d", i), 64'(got_f[i]), 64'(16'(tmp >> (16 * (3 - (i % 4))))));
      chk($sformatf("t2_par%0d", i), 64'(got_p[i]), 64'(exp_par(16'(tmp >> (16 * (3 - (i % 4)))))));
      chk($sformatf("t2_grant%0d", i), 64'(got_g[i]), 64'(i >= 12));
    end

    // Round-robin instance: both sources continuously offer 1-word packets.
    rr_cfg_tvalid = 1'b1; rr_spk_tvalid = 1'b1;
    cyc = 0;
    while (rr_g.size() < 4 && cyc < 100) begin
      #1;
      if (rr_cfg_tready) rr_g.push_back(1'b0);
      if (rr_spk_tready) rr_g.push_back(1'b1);
      tick;
      cyc++;
    end
    rr_cfg_tvalid = 1'b0; rr_spk_tvalid = 1'b0;
    chk("rr_ngrants", 64'(rr_g.size()), 64'd4);
    for (int i = 0; i < 4 && i < rr_g.size(); i++)
      chk($sformatf("rr_grant%0d", i), 64'(rr_g[i]), 64'(i % 2));

    // Parity error after 4567, then again in the last-flit window.
    tick;
    offer_cfg_once(W0);
    chk_flit("e_f0", 16'h0123);
    tick; chk_flit("e_f1", 16'h4567);
    tick; chk_flit("e_f2", 16'h89AB);
    send_data_err = 1'b1;
    tick;
    send_data_err = 1'b0;
`ifdef PCSS_LINK_PARITY_EN
    chk_flit("e_f1_resend", 16'h4567);
    tick; chk_flit("e_f2_resend", 16'h89AB);
    tick; chk_flit("e_f3", 16'hCDEF);
    tick;
    chk("e_chk_valid", 64'(send_data_valid), 64'd0);
    chk("e_chk_busy", 64'(busy), 64'd1);
    send_data_err = 1'b1;
    tick;
    send_data_err = 1'b0;
    chk_flit("e_f3_resend", 16'hCDEF);
    tick;
    chk("e_chk2_valid", 64'(send_data_valid), 64'd0);
    chk("e_chk2_busy", 64'(busy), 64'd1);
    tick;
    chk("e_done_busy", 64'(busy), 64'd0);
`else
    chk_flit("e_f3_noerr", 16'hCDEF);
    tick;
    chk("e_done_valid", 64'(send_data_valid), 64'd0);
    chk("e_done_busy", 64'(busy), 64'd0);
`endif
    tick;

    // Link stall mid-word, then reset during the stall.
    offer_cfg_once(W0);
    chk_flit("s_f0", 16'h0123);
    tick;
    send_data_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_flit($sformatf("s_hold%0d", k), 16'h4567);
      if (k == 4) rst = 1'b1;
      tick;
    end
    chk("s_rst_out", 64'(send_data_out), 64'd0);
    chk("s_rst_valid", 64'(send_data_valid), 64'd0);
    chk("s_rst_par", 64'(send_data_par), 64'd0);
    chk("s_rst_busy", 64'(busy), 64'd0);
    chk("s_rst_grant", 64'(grant_spk), 64'd0);
    chk("s_rst_cfg_tready", 64'(cfg_tready), 64'd0);
    rst = 1'b0;
    send_data_ready = 1'b1;
    tick;
    chk("s_after_valid", 64'(send_data_valid), 64'd0);
    chk("s_after_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
